bus_rx_node: RTL and testbench

- Receive-side endpoint of the single-wire serial node bus driven by the 16-node transmitter fabric (the `bus_show` output).
- Samples the bus one bit per clock, frames each packet, filters on destination address, checks the 4-bit CRC, and presents the 64-bit payload plus source address.
- One instance per node; sits on `bus_show` next to the transmitter.

---
 rtl/bus_rx_node.sv | 208 ++++++++++++++++++++
 tb/tb_bus_rx_node.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_rx_node.sv
// bus_rx_node: receive endpoint for the single-wire serial node bus.
// Samples bus_in once per clock and frames each packet:
//   start(1) src(4) dst(4) data(64) crc(4), all fields MSB first.
// Frames for this node (or for broadcast, when enabled) are CRC-checked;
// good frames update rx_data/rx_src. Either outcome raises a one-cycle pulse.
//
// Ports:
//   clock      - rising-edge clock, one bus bit per cycle
//   reset      - synchronous, active-high
//   bus_in     - serial bus line, idle 0
//   rx_data    - payload of the last accepted frame
//   rx_src     - source address of the last accepted frame
//   rx_valid   - one-cycle pulse, good frame for this node
//   rx_crc_err - one-cycle pulse, addressed frame failed the CRC
//   busy       - high while a frame is being deserialised (not in idle)
//   good_cnt   - saturating count of accepted frames
//   err_cnt    - saturating count of CRC-failed addressed frames
module bus_rx_node #(
  parameter logic [3:0] NODE_ADDR    = 4'd1,
  parameter bit         BROADCAST_EN = 1'b1,
  parameter logic [3:0] CRC_POLY     = 4'b0011
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        bus_in,
  output logic [63:0] rx_data,
  output logic [3:0]  rx_src,
  output logic        rx_valid,
  output logic        rx_crc_err,
  output logic        busy,
  output logic [7:0]  good_cnt,
  output logic [7:0]  err_cnt
);

  typedef enum logic [2:0] {
    StIdle,
    StSrc,
    StDst,
    StData,
    StCrc,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]  src_sr_q, src_sr_d;
  logic [3:0]  dst_sr_q, dst_sr_d;
  logic [63:0] data_sr_q, data_sr_d;
  logic [3:0]  crc_sr_q, crc_sr_d;
  logic [3:0]  crc_q, crc_d;
  logic [63:0] rx_data_q, rx_data_d;
  logic [3:0]  rx_src_q, rx_src_d;
  logic        rx_valid_q, rx_valid_d;
  logic        rx_crc_err_q, rx_crc_err_d;
  logic [7:0]  good_cnt_q, good_cnt_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  logic addr_match;
  logic crc_ok;

  // One serial step of the CRC: remainder of data(x)*x^4 mod g(x).
  function automatic logic [3:0] crc_step(input logic [3:0] c, input logic d);
    logic fb;
    fb = d ^ c[3];
    return {c[2:0], 1'b0} ^ (fb ? CRC_POLY : 4'b0000);
  endfunction

  always_comb begin
    addr_match = (dst_sr_q == NODE_ADDR) || (BROADCAST_EN && (dst_sr_q == 4'hF));
    crc_ok     = (crc_q == crc_sr_q);
  end

  // Next-state and datapath
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    src_sr_d     = src_sr_q;
    dst_sr_d     = dst_sr_q;
    data_sr_d    = data_sr_q;
    crc_sr_d     = crc_sr_q;
    crc_d        = crc_q;
    rx_data_d    = rx_data_q;
    rx_src_d     = rx_src_q;
    rx_valid_d   = 1'b0;
    rx_crc_err_d = 1'b0;
    good_cnt_d   = good_cnt_q;
    err_cnt_d    = err_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (bus_in) begin
          state_d   = StSrc;
          bit_cnt_d = 6'd0;
          crc_d     = 4'h0;
        end
      end

      StSrc: begin
        src_sr_d = {src_sr_q[2:0], bus_in};
        if (bit_cnt_q == 6'd3) begin
          state_d   = StDst;
          bit_cnt_d = 6'd0;
        end else begin
          bit_cnt_d = bit_cnt_q + 6'd1;
        end
      end

      StDst: begin
        dst_sr_d = {dst_sr_q[2:0], bus_in};
        if (bit_cnt_q == 6'd3) begin
          state_d   = StData;
          bit_cnt_d = 6'd0;
        end else begin
          bit_cnt_d = bit_cnt_q + 6'd1;
        end
      end

      StData: begin
        data_sr_d = {data_sr_q[62:0], bus_in};
        crc_d     = crc_step(crc_q, bus_in);
        if (bit_cnt_q == 6'd63) begin
          state_d   = StCrc;
          bit_cnt_d = 6'd0;
        end else begin
          bit_cnt_d = bit_cnt_q + 6'd1;
        end
      end

      StCrc: begin
        crc_sr_d = {crc_sr_q[2:0], bus_in};
        if (bit_cnt_q == 6'd3) begin
          state_d   = StDone;
          bit_cnt_d = 6'd0;
        end else begin
          bit_cnt_d = bit_cnt_q + 6'd1;
        end
      end

      StDone: begin
        if (addr_match) begin
          if (crc_ok) begin
            rx_valid_d = 1'b1;
            rx_data_d  = data_sr_q;
            rx_src_d   = src_sr_q;
            if (good_cnt_q != 8'hFF) good_cnt_d = good_cnt_q + 8'd1;
          end else begin
            rx_crc_err_d = 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          end
        end
        // A 1 here is the start bit of a back-to-back frame.
        if (bus_in) begin
          state_d   = StSrc;
          bit_cnt_d = 6'd0;
          crc_d     = 4'h0;
        end else begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d   = StIdle;
        bit_cnt_d = 6'd0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      bit_cnt_q    <= 6'd0;
      src_sr_q     <= 4'h0;
      dst_sr_q     <= 4'h0;
      data_sr_q    <= 64'h0;
      crc_sr_q     <= 4'h0;
      crc_q        <= 4'h0;
      rx_data_q    <= 64'h0;
      rx_src_q     <= 4'h0;
      rx_valid_q   <= 1'b0;
      rx_crc_err_q <= 1'b0;
      good_cnt_q   <= 8'h0;
      err_cnt_q    <= 8'h0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      src_sr_q     <= src_sr_d;
      dst_sr_q     <= dst_sr_d;
      data_sr_q    <= data_sr_d;
      crc_sr_q     <= crc_sr_d;
      crc_q        <= crc_d;
      rx_data_q    <= rx_data_d;
      rx_src_q     <= rx_src_d;
      rx_valid_q   <= rx_valid_d;
      rx_crc_err_q <= rx_crc_err_d;
      good_cnt_q   <= good_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_src     = rx_src_q;
  assign rx_valid   = rx_valid_q;
  assign rx_crc_err = rx_crc_err_q;
  assign busy       = (state_q != StIdle);
  assign good_cnt   = good_cnt_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_bus_rx_node.sv
// Self-checking bench for bus_rx_node: table of frames plus hand-written
// sequences for back-to-back frames, mid-frame reset and counter saturation.
// Expected pulses are queued when a frame is driven and checked when seen.
module tb_bus_rx_node;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        bus_in = 1'b0;
  logic [63:0] rx_data;
  logic [3:0]  rx_src;
  logic        rx_valid;
  logic        rx_crc_err;
  logic        busy;
  logic [7:0]  good_cnt;
  logic [7:0]  err_cnt;

  bus_rx_node dut (
    .clock      (clock),
    .reset      (reset),
    .bus_in     (bus_in),
    .rx_data    (rx_data),
    .rx_src     (rx_src),
    .rx_valid   (rx_valid),
    .rx_crc_err (rx_crc_err),
    .busy       (busy),
    .good_cnt   (good_cnt),
    .err_cnt    (err_cnt)
  );

  always #5 clock = ~clock;

  localparam int KNone  = 0;
  localparam int KValid = 1;
  localparam int KErr   = 2;

  typedef struct {
    logic [3:0]  src;
    logic [3:0]  dst;
    logic [63:0] data;
    logic [3:0]  crc;
    int          kind;
  } vec_t;

  typedef struct {
    int          kind;
    int          due;
    logic [63:0] data;
    logic [3:0]  src;
    logic [7:0]  good;
    logic [7:0]  err;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          busy_run = 0;
  int          last_busy = 0;

  // Reference state of the receiver outputs
  logic [63:0] mdl_data = 64'h0;
  logic [3:0]  mdl_src  = 4'h0;
  logic [7:0]  mdl_good = 8'h0;
  logic [7:0]  mdl_err  = 8'h0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] crc4(input logic [63:0] d);
    logic [3:0] c;
    logic       fb;
    c = 4'h0;
    for (int i = 63; i >= 0; i--) begin
      fb = d[i] ^ c[3];
      c  = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
    end
    return c;
  endfunction

  // Pulse monitor / scoreboard pop
  always @(negedge clock) begin
    exp_t e;
    if (busy) busy_run++;
    else if (busy_run != 0) begin
      last_busy = busy_run;
      busy_run  = 0;
    end
    if (!reset) begin
      if (rx_valid && rx_crc_err) chk("pulses_exclusive", 64'd1, 64'd0);
      if (rx_valid || rx_crc_err) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse", {62'd0, rx_crc_err, rx_valid}, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("pulse_kind", rx_valid ? 64'd1 : 64'd2, 64'(e.kind));
          chk("pulse_cycle", 64'(cyc), 64'(e.due));
          chk("rx_data", rx_data, e.data);
          chk("rx_src", 64'(rx_src), 64'(e.src));
          chk("good_cnt", 64'(good_cnt), 64'(e.good));
          chk("err_cnt", 64'(err_cnt), 64'(e.err));
        end
      end else if (sb.size() > 0 && cyc > sb[0].due) begin
        e = sb.pop_front();
        chk("missing_pulse", 64'd0, 64'(e.kind));
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      bus_in = 1'b0;
    end
  endtask

  task automatic send_frame(input vec_t v);
    logic [76:0] f;
    exp_t        e;
    f = {1'b1, v.src, v.dst, v.data, v.crc};
    @(negedge clock);
    // Start bit is sampled at posedge cyc+1; pulse visible after posedge k+77.
    if (v.kind == KValid) begin
      mdl_data = v.data;
      mdl_src  = v.src;
      if (mdl_good != 8'hFF) mdl_good = mdl_good + 8'd1;
    end else if (v.kind == KErr) begin
      if (mdl_err != 8'hFF) mdl_err = mdl_err + 8'd1;
    end
    if (v.kind != KNone) begin
      e.kind = v.kind;
      e.due  = cyc + 1 + 77;
      e.data = mdl_data;
      e.src  = mdl_src;
      e.good = mdl_good;
      e.err  = mdl_err;
      sb.push_back(e);
    end
    bus_in = f[76];
    for (int i = 75; i >= 0; i--) begin
      @(negedge clock);
      bus_in = f[i];
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_rx_data"}, rx_data, 64'h0);
    chk({tag, "_rx_src"}, 64'(rx_src), 64'h0);
    chk({tag, "_pulses"}, {62'd0, rx_valid, rx_crc_err}, 64'h0);
    chk({tag, "_busy"}, 64'(busy), 64'h0);
    chk({tag, "_good_cnt"}, 64'(good_cnt), 64'h0);
    chk({tag, "_err_cnt"}, 64'(err_cnt), 64'h0);
  endtask

  vec_t tbl[4];
  vec_t v;
  vec_t v2;

  initial begin
    tbl[0] = '{src: 4'd2, dst: 4'd1, data: 64'h1, crc: 4'h3, kind: KValid};
    tbl[1] = '{src: 4'd2, dst: 4'd1, data: 64'h1, crc: 4'h1, kind: KErr};
    tbl[2] = '{src: 4'd3, dst: 4'd5, data: 64'hDEADBEEF00000000,
               crc: crc4(64'hDEADBEEF00000000), kind: KNone};
    tbl[3] = '{src: 4'd4, dst: 4'hF, data: 64'h0, crc: 4'h0, kind: KValid};

    // Reset and idle
    reset  = 1'b1;
    bus_in = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk_idle_outputs("reset");
    reset = 1'b0;
    idle(20);
    chk_idle_outputs("idle20");

    // Table of single frames, each followed by an idle gap
    for (int i = 0; i < 4; i++) begin
      send_frame(tbl[i]);
      idle(5);
      chk($sformatf("tbl%0d_good_cnt", i), 64'(good_cnt), 64'(mdl_good));
      chk($sformatf("tbl%0d_err_cnt", i), 64'(err_cnt), 64'(mdl_err));
      chk($sformatf("tbl%0d_rx_data", i), rx_data, mdl_data);
      chk($sformatf("tbl%0d_rx_src", i), 64'(rx_src), 64'(mdl_src));
      if (i == 2) chk("nomatch_busy_len", 64'(last_busy), 64'd77);
    end

    // Back-to-back frames, no gap
    v  = '{src: 4'd6, dst: 4'd1, data: 64'hA5A5A5A5A5A5A5A5,
           crc: crc4(64'hA5A5A5A5A5A5A5A5), kind: KValid};
    v2 = '{src: 4'd7, dst: 4'd1, data: 64'h1, crc: 4'h3, kind: KValid};
    send_frame(v);
    send_frame(v2);
    idle(5);
    chk("b2b_good_cnt", 64'(good_cnt), 64'd4);
    chk("b2b_rx_data", rx_data, 64'h1);
    chk("b2b_rx_src", 64'(rx_src), 64'd7);

    // Reset at data bit 30 of a frame
    begin
      logic [76:0] f;
      f = {1'b1, 4'd2, 4'd1, 64'hFFFF_FFFF_FFFF_FFFF, 4'h0};
      for (int i = 76; i > 76 - 9 - 30; i--) begin
        @(negedge clock);
        bus_in = f[i];
      end
    end
    @(negedge clock);
    bus_in = 1'b0;
    reset  = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk_idle_outputs("midreset");
    reset = 1'b0;
    sb.delete();
    mdl_data = 64'h0;
    mdl_src  = 4'h0;
    mdl_good = 8'h0;
    mdl_err  = 8'h0;
    idle(10);
    chk_idle_outputs("post_reset_idle");
    send_frame(tbl[0]);
    idle(5);
    chk("resync_good_cnt", 64'(good_cnt), 64'd1);
    chk("resync_rx_data", rx_data, 64'h1);

    // Saturation of good_cnt
    for (int i = 0; i < 260; i++) begin
      v = '{src: 4'(i), dst: (i % 2 == 0) ? 4'd1 : 4'hF, data: 64'(i) * 64'h9E3779B97F4A7C15,
            crc: 4'h0, kind: KValid};
      v.crc = crc4(v.data);
      send_frame(v);
    end
    idle(10);
    chk("sat_good_cnt", 64'(good_cnt), 64'd255);
    chk("sat_err_cnt", 64'(err_cnt), 64'd0);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
